// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the decode/writeback side of the register file scoreboard.
//   master: decode + writeback logic (drives addresses, write and issue strobes)
//   slave : regfile_scoreboard (returns read data, busy flags, any_busy)
//   Signals:
//     read_addr    NRD*AW    packed read addresses, port k at [k*AW +: AW]
//     read_data    NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
//     read_busy    NRD       per-port outstanding-write flag
//     write_enable/write_addr/write_data  writeback port
//     issue_valid/issue_addr              destination being marked pending
//     flush                               clear all pending flags
//     any_busy                            OR of all pending flags
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   read_addr;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      read_busy;
    logic                write_enable;
    logic [AW-1:0]       write_addr;
    logic [XLEN-1:0]     write_data;
    logic                issue_valid;
    logic [AW-1:0]       issue_addr;
    logic                flush;
    logic                any_busy;

    modport master (
        output read_addr,
        input  read_data,
        input  read_busy,
        output write_enable,
        output write_addr,
        output write_data,
        output issue_valid,
        output issue_addr,
        output flush,
        input  any_busy
    );

    modport slave (
        input  read_addr,
        output read_data,
        output read_busy,
        input  write_enable,
        input  write_addr,
        input  write_data,
        input  issue_valid,
        input  issue_addr,
        input  flush,
        output any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file with a pending-write scoreboard. Reads are
//   combinational with one mux per port; writes and pending-flag updates
//   happen on the rising edge of clk. reset is synchronous, active-high.
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset (clears registers and pending)
//     bus    regfile_scoreboard_if.slave (read ports, write port, issue, flush)
//   Optional feature: define REGFILE_BYPASS_EN to forward the writeback data
//   and clear read_busy in the write cycle itself.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    pending_q;
    logic [NREGS-1:0]    pending_d;

    logic [NRD*XLEN-1:0] read_data_c;
    logic [NRD-1:0]      read_busy_c;
    logic [AW-1:0]       ra;
    logic [XLEN-1:0]     rd;
    logic                rb;

    // Register 0 is hardwired when ZERO_REG is set.
    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (bus.write_enable && !is_zero(bus.write_addr)) begin
            regs_d[bus.write_addr] = bus.write_data;
        end
    end

    // Issue is applied after the write clear so a same-cycle issue and
    // write to one register leaves the new writer outstanding.
    always_comb begin
        pending_d = pending_q;
        if (bus.flush) begin
            pending_d = '0;
        end else begin
            if (bus.write_enable) begin
                pending_d[bus.write_addr] = 1'b0;
            end
            if (bus.issue_valid && !is_zero(bus.issue_addr)) begin
                pending_d[bus.issue_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        read_data_c = '0;
        read_busy_c = '0;
        ra          = '0;
        rd          = '0;
        rb          = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.read_addr[k*AW +: AW];
            rd = regs_q[ra];
            rb = pending_q[ra];
            if (is_zero(ra)) begin
                rd = '0;
                rb = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the writeback; busy stays up only if a new writer to
            // the same register is issued this cycle.
            if (bus.write_enable && (ra == bus.write_addr) && !is_zero(ra)) begin
                rd = bus.write_data;
                rb = bus.issue_valid && (bus.issue_addr == ra);
            end
`endif
            read_data_c[k*XLEN +: XLEN] = rd;
            read_busy_c[k]              = rb;
        end
    end

    assign bus.read_data = read_data_c;
    assign bus.read_busy = read_busy_c;
    assign bus.any_busy  = |pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    bit   started;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents and outstanding-writer set.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_pend [NREGS];

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (bus.write_enable && bus.write_addr != 0)
                m_reg[bus.write_addr] = bus.write_data;
            if (bus.flush) begin
                for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
            end else begin
                if (bus.write_enable) m_pend[bus.write_addr] = 1'b0;
                if (bus.issue_valid && bus.issue_addr != 0) m_pend[bus.issue_addr] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] ed;
            bit              eb;
            bit              hit;
            bit              anyb;
            for (int k = 0; k < NRD; k++) begin
                a   = bus.read_addr[k*AW +: AW];
                hit = BYP && bus.write_enable && (a == bus.write_addr) && (a != 0);
                if (a == 0) begin
                    ed = '0; eb = 1'b0;
                end else if (hit) begin
                    ed = bus.write_data;
                    eb = bus.issue_valid && (bus.issue_addr == a);
                end else begin
                    ed = m_reg[a]; eb = m_pend[a];
                end
                check($sformatf("cyc_p%0d_data", k), bus.read_data[k*XLEN +: XLEN], ed);
                check($sformatf("cyc_p%0d_busy", k), {31'b0, bus.read_busy[k]}, {31'b0, eb});
            end
            anyb = 1'b0;
            for (int i = 0; i < NREGS; i++) anyb |= m_pend[i];
            check("cyc_any_busy", {31'b0, bus.any_busy}, {31'b0, anyb});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_enable = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.flush        = 1'b0;
        reset            = 1'b0;
    endtask

    task automatic set_ra(input int k, input int a);
        bus.read_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [31:0] rdp(input int k);
        return bus.read_data[k*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] rbp(input int k);
        return {31'b0, bus.read_busy[k]};
    endfunction

    initial begin
        checks = 0; failures = 0; started = 1'b0;
        reset = 1'b1;
        bus.read_addr = '0; bus.write_enable = 1'b0; bus.write_addr = '0;
        bus.write_data = '0; bus.issue_valid = 1'b0; bus.issue_addr = '0;
        bus.flush = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        started = 1'b1;
        for (int k = 0; k < NRD; k++) set_ra(k, k + 5);
        #1;
        for (int k = 0; k < NRD; k++) check($sformatf("rst_p%0d_data", k), rdp(k), 32'h0);
        check("rst_any_busy", {31'b0, bus.any_busy}, 32'h0);

        // reset and zero register
        bus.write_enable = 1'b1; bus.write_addr = 5; bus.write_data = 32'hDEADBEEF;
        cyc(); idle(); set_ra(0, 5); #1;
        check("x5_written", rdp(0), 32'hDEADBEEF);
        reset = 1'b1;
        cyc(); idle(); #1;
        check("x5_after_reset", rdp(0), 32'h0);
        bus.write_enable = 1'b1; bus.write_addr = 0; bus.write_data = 32'h1234;
        cyc(); idle(); set_ra(0, 0); #1;
        check("x0_reads_zero", rdp(0), 32'h0);
        check("x0_any_busy", {31'b0, bus.any_busy}, 32'h0);

        // write x1..x4 then read on all four ports
        for (int i = 1; i <= 4; i++) begin
            bus.write_enable = 1'b1; bus.write_addr = AW'(i); bus.write_data = 32'(i * 32'h11);
            cyc();
        end
        idle();
        for (int k = 0; k < NRD; k++) set_ra(k, k + 1);
        #1;
        check("x1_p0", rdp(0), 32'h11);
        check("x2_p1", rdp(1), 32'h22);
        check("x3_p2", rdp(2), 32'h33);
        check("x4_p3", rdp(3), 32'h44);

        // scoreboard set/clear on x7
        bus.issue_valid = 1'b1; bus.issue_addr = 7;
        cyc(); idle(); set_ra(0, 7); #1;
        check("x7_busy_after_issue", rbp(0), 32'h1);
        check("x7_any_busy", {31'b0, bus.any_busy}, 32'h1);
        cyc();
        check("x7_busy_hold", rbp(0), 32'h1);
        bus.write_enable = 1'b1; bus.write_addr = 7; bus.write_data = 32'hA5; #1;
        check("x7_busy_write_cycle", rbp(0), BYP ? 32'h0 : 32'h1);
        check("x7_data_write_cycle", rdp(0), BYP ? 32'hA5 : 32'h0);
        cyc(); idle(); #1;
        check("x7_busy_after_write", rbp(0), 32'h0);
        check("x7_data_after_write", rdp(0), 32'hA5);

        // simultaneous issue and write to x9
        bus.issue_valid = 1'b1; bus.issue_addr = 9;
        cyc();
        bus.write_enable = 1'b1; bus.write_addr = 9; bus.write_data = 32'h55;
        set_ra(1, 9); #1;
        check("x9_busy_issue_write_cycle", rbp(1), 32'h1);
        cyc(); idle(); #1;
        check("x9_busy_after", rbp(1), 32'h1);
        check("x9_data_after", rdp(1), 32'h55);
        bus.write_enable = 1'b1; bus.write_addr = 9; bus.write_data = 32'h66;
        cyc(); idle(); #1;
        check("x9_cleared", rbp(1), 32'h0);

        // flush beats a same-cycle issue
        bus.issue_valid = 1'b1; bus.issue_addr = 3; cyc();
        bus.issue_addr = 4; cyc();
        idle(); set_ra(0, 3); set_ra(1, 4); set_ra(2, 6); #1;
        check("x3_pending", rbp(0), 32'h1);
        check("x4_pending", rbp(1), 32'h1);
        bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_addr = 6;
        cyc(); idle(); #1;
        check("flush_x3", rbp(0), 32'h0);
        check("flush_x4", rbp(1), 32'h0);
        check("flush_x6_dropped", rbp(2), 32'h0);
        check("flush_any_busy", {31'b0, bus.any_busy}, 32'h0);

        // issue to x0 has no effect; write to a non-pending register
        bus.issue_valid = 1'b1; bus.issue_addr = 0; cyc(); idle(); #1;
        check("x0_issue_any_busy", {31'b0, bus.any_busy}, 32'h0);
        bus.write_enable = 1'b1; bus.write_addr = 12; bus.write_data = 32'hC0FFEE;
        cyc(); idle(); set_ra(3, 12); #1;
        check("x12_not_busy", rbp(3), 32'h0);
        check("x12_data", rdp(3), 32'hC0FFEE);

        // reset mid-operation beats issue and write
        bus.issue_valid = 1'b1; bus.issue_addr = 10; cyc(); idle();
        set_ra(0, 10); #1;
        check("x10_pending", rbp(0), 32'h1);
        reset = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_addr = 10;
        bus.write_enable = 1'b1; bus.write_addr = 10; bus.write_data = 32'hFF;
        cyc(); idle(); #1;
        check("x10_data_after_reset", rdp(0), 32'h0);
        check("x10_busy_after_reset", rbp(0), 32'h0);

        // overlapping issue/write stream, checked every cycle by the model
        for (int i = 0; i < 8; i++) begin
            bus.issue_valid  = 1'b1;
            bus.issue_addr   = AW'(16 + i);
            bus.write_enable = (i > 0);
            bus.write_addr   = AW'(15 + i);
            bus.write_data   = 32'(i * 32'h101);
            for (int k = 0; k < NRD; k++) set_ra(k, 14 + i + k);
            cyc();
        end
        idle();
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
